// File: rtl/ring_out_stage.sv
// Ring output stage: priority mux of agent drives over the upstream slot, one register stage,
// and on the master node a Token injector guarded by a watchdog.
module ring_out_stage #(
    parameter int unsigned INIT_DELAY    = 16,
    parameter int unsigned TOKEN_TIMEOUT = 1024,
    parameter logic [3:0]  NULL_T        = 4'd7,
    parameter logic [3:0]  TOKEN_T       = 4'd1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SrcDestIn,

    input  logic [31:0] msgrRingOut,
    input  logic [3:0]  msgrSlotTypeOut,
    input  logic [3:0]  msgrSrcDestOut,
    input  logic        msgrDriveRing,

    input  logic [31:0] lockRingOut,
    input  logic [3:0]  lockSlotTypeOut,
    input  logic [3:0]  lockSrcDestOut,
    input  logic        lockDriveRing,

    input  logic [31:0] barrierRingOut,
    input  logic [3:0]  barrierSlotTypeOut,
    input  logic [3:0]  barrierSrcDestOut,
    input  logic        barrierDriveRing,

    input  logic        isMaster,
    input  logic [3:0]  whichCore,
    input  logic        clearErr,

    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SrcDestOut,
    output logic        collision,
    output logic        tokenLost
);

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StInject
    } state_e;

    // Inject on the edge where the watchdog would reach TOKEN_TIMEOUT-1.
    localparam logic [15:0] WdLast   = 16'(TOKEN_TIMEOUT - 32'd2);
    localparam logic [31:0] InitLast = (INIT_DELAY == 0) ? 32'd0 : 32'(INIT_DELAY - 1);

    state_e      state_q, state_d;
    logic [31:0] init_cnt_q, init_cnt_d;
    logic [15:0] wd_q, wd_d;

    logic [31:0] ring_q, ring_d;
    logic [3:0]  type_q, type_d;
    logic [3:0]  sd_q, sd_d;
    logic        coll_q, coll_d;
    logic        lost_q, lost_d;

    logic [31:0] sel_data;
    logic [3:0]  sel_type;
    logic [3:0]  sel_sd;
    logic        any_drive;
    logic        multi_drive;
    logic        slot_free;
    logic        timeout_hit;

    always_comb begin
        sel_data = RingIn;
        sel_type = SlotTypeIn;
        sel_sd   = SrcDestIn;
        if (msgrDriveRing) begin
            sel_data = msgrRingOut;
            sel_type = msgrSlotTypeOut;
            sel_sd   = msgrSrcDestOut;
        end else if (lockDriveRing) begin
            sel_data = lockRingOut;
            sel_type = lockSlotTypeOut;
            sel_sd   = lockSrcDestOut;
        end else if (barrierDriveRing) begin
            sel_data = barrierRingOut;
            sel_type = barrierSlotTypeOut;
            sel_sd   = barrierSrcDestOut;
        end
    end

    assign any_drive   = msgrDriveRing | lockDriveRing | barrierDriveRing;
    assign multi_drive = (msgrDriveRing & lockDriveRing) | (msgrDriveRing & barrierDriveRing) |
                         (lockDriveRing & barrierDriveRing);
    assign slot_free   = (sel_type == NULL_T) && !any_drive;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        wd_d        = wd_q;
        ring_d      = sel_data;
        type_d      = sel_type;
        sd_d        = sel_sd;
        timeout_hit = 1'b0;

        if (!isMaster) begin
            state_d = StRun;
            wd_d    = '0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (init_cnt_q >= InitLast) begin
                        state_d = StInject;
                    end else begin
                        init_cnt_d = init_cnt_q + 32'd1;
                    end
                end
                StRun: begin
                    if (type_q == TOKEN_T) begin
                        wd_d = '0;
                    end else if (wd_q >= WdLast) begin
                        wd_d        = '0;
                        state_d     = StInject;
                        timeout_hit = 1'b1;
                    end else begin
                        wd_d = wd_q + 16'd1;
                    end
                end
                StInject: begin
                    if (slot_free) begin
                        ring_d  = '0;
                        type_d  = TOKEN_T;
                        sd_d    = whichCore;
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // A set event in the same cycle beats clearErr.
    always_comb begin
        coll_d = coll_q;
        lost_d = lost_q;
        if (multi_drive) begin
            coll_d = 1'b1;
        end else if (clearErr) begin
            coll_d = 1'b0;
        end
        if (timeout_hit) begin
            lost_d = 1'b1;
        end else if (clearErr) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= isMaster ? StInit : StRun;
            init_cnt_q <= '0;
            wd_q       <= '0;
            ring_q     <= '0;
            type_q     <= NULL_T;
            sd_q       <= '0;
            coll_q     <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            wd_q       <= wd_d;
            ring_q     <= ring_d;
            type_q     <= type_d;
            sd_q       <= sd_d;
            coll_q     <= coll_d;
            lost_q     <= lost_d;
        end
    end

    assign RingOut     = ring_q;
    assign SlotTypeOut = type_q;
    assign SrcDestOut  = sd_q;
    assign collision   = coll_q;
    assign tokenLost   = lost_q;

endmodule

// File: tb/tb_ring_out_stage.sv
// Bench for ring_out_stage: table-driven forwarding/collision vectors plus master Token sequences,
// all checked through a one-deep expected-output queue.
module tb_ring_out_stage;

    localparam int unsigned InitDelay = 16;
    localparam int unsigned Timeout   = 64;
    localparam logic [3:0]  NullT     = 4'd7;
    localparam logic [3:0]  TokenT    = 4'd1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] RingIn;
    logic [3:0]  SlotTypeIn, SrcDestIn;
    logic [31:0] msgrRingOut, lockRingOut, barrierRingOut;
    logic [3:0]  msgrSlotTypeOut, lockSlotTypeOut, barrierSlotTypeOut;
    logic [3:0]  msgrSrcDestOut, lockSrcDestOut, barrierSrcDestOut;
    logic        msgrDriveRing, lockDriveRing, barrierDriveRing;
    logic        isMaster, clearErr;
    logic [3:0]  whichCore;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut, SrcDestOut;
    logic        collision, tokenLost;

    ring_out_stage #(
        .INIT_DELAY    (InitDelay),
        .TOKEN_TIMEOUT (Timeout),
        .NULL_T        (NullT),
        .TOKEN_T       (TokenT)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .RingIn             (RingIn),
        .SlotTypeIn         (SlotTypeIn),
        .SrcDestIn          (SrcDestIn),
        .msgrRingOut        (msgrRingOut),
        .msgrSlotTypeOut    (msgrSlotTypeOut),
        .msgrSrcDestOut     (msgrSrcDestOut),
        .msgrDriveRing      (msgrDriveRing),
        .lockRingOut        (lockRingOut),
        .lockSlotTypeOut    (lockSlotTypeOut),
        .lockSrcDestOut     (lockSrcDestOut),
        .lockDriveRing      (lockDriveRing),
        .barrierRingOut     (barrierRingOut),
        .barrierSlotTypeOut (barrierSlotTypeOut),
        .barrierSrcDestOut  (barrierSrcDestOut),
        .barrierDriveRing   (barrierDriveRing),
        .isMaster           (isMaster),
        .whichCore          (whichCore),
        .clearErr           (clearErr),
        .RingOut            (RingOut),
        .SlotTypeOut        (SlotTypeOut),
        .SrcDestOut         (SrcDestOut),
        .collision          (collision),
        .tokenLost          (tokenLost)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] data;
        logic [3:0]  sd;
        logic        coll;
        logic        lost;
    } obs_t;

    typedef struct {
        logic [2:0]  drv;   // {msgr, lock, barrier}
        logic        clr;
        logic [3:0]  in_st;
        logic [31:0] in_data;
        logic [3:0]  in_sd;
        logic [3:0]  e_st;
        logic [31:0] e_data;
        logic [3:0]  e_sd;
        logic        e_coll;
    } vec_t;

    obs_t sb_q[$];
    vec_t vecs[11];
    int   tests = 0;
    int   fails = 0;

    task automatic expect_obs(input logic [3:0] st, input logic [31:0] data, input logic [3:0] sd,
                              input logic coll, input logic lost);
        obs_t e;
        e.st   = st;
        e.data = data;
        e.sd   = sd;
        e.coll = coll;
        e.lost = lost;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance one clock and compare the registered outputs against the oldest expectation.
    task automatic step(input string name);
        obs_t exp_o;
        tick();
        tests++;
        if (sb_q.size() == 0) begin
            fails++;
            $display("FAIL %s: no expectation queued (type=%0d data=%h)", name, SlotTypeOut,
                     RingOut);
        end else begin
            exp_o = sb_q.pop_front();
            if (SlotTypeOut !== exp_o.st || RingOut !== exp_o.data || SrcDestOut !== exp_o.sd ||
                collision !== exp_o.coll || tokenLost !== exp_o.lost) begin
                fails++;
                $display("FAIL %s: got type=%0d data=%h sd=%0d coll=%b lost=%b, want type=%0d data=%h sd=%0d coll=%b lost=%b",
                         name, SlotTypeOut, RingOut, SrcDestOut, collision, tokenLost,
                         exp_o.st, exp_o.data, exp_o.sd, exp_o.coll, exp_o.lost);
            end
        end
    endtask

    task automatic set_up(input logic [3:0] st, input logic [31:0] data, input logic [3:0] sd);
        SlotTypeIn = st;
        RingIn     = data;
        SrcDestIn  = sd;
    endtask

    task automatic do_reset(input logic master);
        reset            = 1'b1;
        isMaster         = master;
        msgrDriveRing    = 1'b0;
        lockDriveRing    = 1'b0;
        barrierDriveRing = 1'b0;
        clearErr         = 1'b0;
        set_up(NullT, 32'd0, 4'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    function automatic vec_t mkv(input logic [2:0] drv, input logic clr, input logic [3:0] in_st,
                                 input logic [31:0] in_data, input logic [3:0] in_sd,
                                 input logic [3:0] e_st, input logic [31:0] e_data,
                                 input logic [3:0] e_sd, input logic e_coll);
        vec_t v;
        v.drv = drv;  v.clr = clr;
        v.in_st = in_st;  v.in_data = in_data;  v.in_sd = in_sd;
        v.e_st = e_st;  v.e_data = e_data;  v.e_sd = e_sd;  v.e_coll = e_coll;
        return v;
    endfunction

    initial begin
        msgrRingOut        = 32'h1111_0001;  msgrSlotTypeOut    = 4'd3;  msgrSrcDestOut    = 4'd4;
        lockRingOut        = 32'h2222_0002;  lockSlotTypeOut    = 4'd5;  lockSrcDestOut    = 4'd5;
        barrierRingOut     = 32'h0000_0005;  barrierSlotTypeOut = 4'd13; barrierSrcDestOut = 4'd2;
        whichCore          = 4'd3;
        isMaster           = 1'b0;
        clearErr           = 1'b0;
        msgrDriveRing      = 1'b0;
        lockDriveRing      = 1'b0;
        barrierDriveRing   = 1'b0;
        set_up(NullT, 32'd0, 4'd0);

        vecs[0]  = mkv(3'b000, 1'b0, 4'd2, 32'hCAFE_0000, 4'd1, 4'd2, 32'hCAFE_0000, 4'd1, 1'b0);
        vecs[1]  = mkv(3'b001, 1'b0, 4'd2, 32'hCAFE_0001, 4'd1, 4'd13, 32'h0000_0005, 4'd2, 1'b0);
        vecs[2]  = mkv(3'b011, 1'b0, 4'd2, 32'hCAFE_0002, 4'd1, 4'd5, 32'h2222_0002, 4'd5, 1'b1);
        vecs[3]  = mkv(3'b000, 1'b1, 4'd2, 32'hCAFE_0003, 4'd1, 4'd2, 32'hCAFE_0003, 4'd1, 1'b0);
        vecs[4]  = mkv(3'b110, 1'b0, 4'd2, 32'hCAFE_0004, 4'd1, 4'd3, 32'h1111_0001, 4'd4, 1'b1);
        vecs[5]  = mkv(3'b000, 1'b0, 4'd2, 32'hCAFE_0005, 4'd1, 4'd2, 32'hCAFE_0005, 4'd1, 1'b1);
        vecs[6]  = mkv(3'b111, 1'b1, 4'd2, 32'hCAFE_0006, 4'd1, 4'd3, 32'h1111_0001, 4'd4, 1'b1);
        vecs[7]  = mkv(3'b000, 1'b1, 4'd2, 32'hCAFE_0007, 4'd1, 4'd2, 32'hCAFE_0007, 4'd1, 1'b0);
        vecs[8]  = mkv(3'b100, 1'b0, 4'd2, 32'hCAFE_0008, 4'd1, 4'd3, 32'h1111_0001, 4'd4, 1'b0);
        vecs[9]  = mkv(3'b010, 1'b0, 4'd2, 32'hCAFE_0009, 4'd1, 4'd5, 32'h2222_0002, 4'd5, 1'b0);
        vecs[10] = mkv(3'b000, 1'b0, NullT, 32'h0000_0000, 4'd0, NullT, 32'h0000_0000, 4'd0, 1'b0);

        // Reset values, with a colliding agent drive and a non-Null upstream slot present.
        reset         = 1'b1;
        msgrDriveRing = 1'b1;
        lockDriveRing = 1'b1;
        set_up(4'd2, 32'hFFFF_FFFF, 4'd9);
        for (int i = 0; i < 2; i++) begin
            expect_obs(NullT, 32'd0, 4'd0, 1'b0, 1'b0);
            step("reset_state");
        end

        // Forwarding priority and sticky collision, non-master.
        do_reset(1'b0);
        for (int i = 0; i < 11; i++) begin
            {msgrDriveRing, lockDriveRing, barrierDriveRing} = vecs[i].drv;
            clearErr = vecs[i].clr;
            set_up(vecs[i].in_st, vecs[i].in_data, vecs[i].in_sd);
            expect_obs(vecs[i].e_st, vecs[i].e_data, vecs[i].e_sd, vecs[i].e_coll, 1'b0);
            step($sformatf("vec%0d", i));
        end
        msgrDriveRing    = 1'b0;
        lockDriveRing    = 1'b0;
        barrierDriveRing = 1'b0;
        clearErr         = 1'b0;

        // Non-master never injects, even far past the timeout.
        do_reset(1'b0);
        for (int i = 0; i < 5000; i++) begin
            set_up(NullT, i, 4'(i));
            expect_obs(NullT, i, 4'(i), 1'b0, 1'b0);
            step("nonmaster_idle");
        end

        // Master start-up: single Token INIT_DELAY+1 cycles after reset release.
        do_reset(1'b1);
        for (int k = 1; k <= 20; k++) begin
            set_up(NullT, 32'd0, 4'd0);
            if (k == InitDelay + 1) expect_obs(TokenT, 32'd0, 4'd3, 1'b0, 1'b0);
            else                    expect_obs(NullT, 32'd0, 4'd0, 1'b0, 1'b0);
            step($sformatf("init_k%0d", k));
        end

        // Token circulates every 50 cycles, then stops after i=250; the watchdog sees 64
        // Token-free output cycles (251..314) and the injected Token lands at i=315.
        for (int i = 0; i < 350; i++) begin
            if (i % 50 == 0 && i <= 250) begin
                set_up(TokenT, 32'h7000_0000 + i, 4'd9);
                expect_obs(TokenT, 32'h7000_0000 + i, 4'd9, 1'b0, 1'b0);
            end else begin
                set_up(NullT, 32'd0, 4'd0);
                if (i == 315) expect_obs(TokenT, 32'd0, 4'd3, 1'b0, 1'b1);
                else          expect_obs(NullT, 32'd0, 4'd0, 1'b0, i >= 314);
            end
            step($sformatf("watchdog_i%0d", i));
        end

        // clearErr drops tokenLost when nothing sets it in the same cycle.
        clearErr = 1'b1;
        expect_obs(NullT, 32'd0, 4'd0, 1'b0, 1'b0);
        step("lost_clear");
        clearErr = 1'b0;

        // INJECT pending while upstream is busy for 10 cycles.
        do_reset(1'b1);
        for (int k = 1; k <= 30; k++) begin
            if (k >= 17 && k <= 26) begin
                set_up(4'd2, 32'hA000_0000 + k, 4'(k));
                expect_obs(4'd2, 32'hA000_0000 + k, 4'(k), 1'b0, 1'b0);
            end else begin
                set_up(NullT, 32'd0, 4'd0);
                if (k == 27) expect_obs(TokenT, 32'd0, 4'd3, 1'b0, 1'b0);
                else         expect_obs(NullT, 32'd0, 4'd0, 1'b0, 1'b0);
            end
            step($sformatf("busy_k%0d", k));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ring_out_stage.md
RING_OUT_STAGE -- requirements
Module: ring_out_stage

Interface
REQ-001 SHALL have parameter INIT_DELAY, default 16: cycles after reset before the master injects the first Token.
REQ-002 SHALL have parameter TOKEN_TIMEOUT, default 1024: cycles without an outgoing Token before the master re-injects one (range 2..65535).
REQ-003 SHALL have parameters NULL_T, default 7, and TOKEN_T, default 1: the slot-type encodings.
REQ-004 SHALL have port clock  in  1  system clock, rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports RingIn / SlotTypeIn / SrcDestIn  in  32/4/4  slot arriving from the upstream node.
REQ-007 SHALL have ports msgrRingOut / msgrSlotTypeOut / msgrSrcDestOut / msgrDriveRing  in  32/4/4/1  messenger agent drive.
REQ-008 SHALL have ports lockRingOut / lockSlotTypeOut / lockSrcDestOut / lockDriveRing  in  32/4/4/1  locker agent drive.
REQ-009 SHALL have ports barrierRingOut / barrierSlotTypeOut / barrierSrcDestOut / barrierDriveRing  in  32/4/4/1  barrier agent drive.
REQ-010 SHALL have port isMaster  in  1  this node generates and guards the Token.
REQ-011 SHALL have port whichCore  in  4  node id, used as SrcDest of an injected Token.
REQ-012 SHALL have port clearErr  in  1  clears the sticky flags.
REQ-013 SHALL have ports RingOut / SlotTypeOut / SrcDestOut  out  32/4/4  registered slot to the downstream node.
REQ-014 SHALL have port collision  out  1  sticky: more than one agent drove in the same cycle.
REQ-015 SHALL have port tokenLost  out  1  sticky: the watchdog re-injected a Token.

Function
REQ-016 SHALL select the slot source combinationally by fixed priority: messenger > locker > barrier > pass-through of RingIn/SlotTypeIn/SrcDestIn.
REQ-017 SHALL register the selected slot, giving exactly 1 cycle latency from input to RingOut/SlotTypeOut/SrcDestOut.
REQ-018 SHALL set collision in the cycle after two or more DriveRing inputs are high together; the priority winner is still forwarded.
REQ-019 SHALL have the master FSM states INIT, RUN and INJECT; a non-master SHALL stay in RUN and never inject.
REQ-020 SHALL, in INIT, count up to INIT_DELAY cycles, then enter INJECT.
REQ-021 SHALL, in INJECT, wait for a cycle where the selected slot type equals NULL_T and no DriveRing is high; that cycle's registered output SHALL be {TOKEN_T, RingOut=0, SrcDestOut=whichCore}, after which the FSM enters RUN.
REQ-022 SHALL, in INJECT, forward any non-Null or driven slot unchanged and keep waiting; INJECT SHALL have no timeout.
REQ-023 SHALL, in RUN, run a 16-bit watchdog that clears on any cycle where the registered SlotTypeOut equals TOKEN_T and otherwise increments.
REQ-024 SHALL, when the watchdog reaches TOKEN_TIMEOUT-1 in RUN, enter INJECT, clear the watchdog and set tokenLost.
REQ-025 SHALL NOT let the watchdog wrap; it holds its value outside RUN.
REQ-026 SHALL give clearErr lower priority than a same-cycle set event, so the flag stays 1.
REQ-027 SHALL have isMaster and whichCore static after reset; deasserting isMaster mid-operation forces RUN on the next cycle.

Reset
REQ-028 SHALL, on reset, drive SlotTypeOut=NULL_T, RingOut=0, SrcDestOut=0, collision=0 and tokenLost=0, and clear the watchdog and INIT counters.
REQ-029 SHALL enter INIT on reset if isMaster=1, else RUN; reset mid-INJECT abandons the pending injection.

Verification
REQ-030 SHALL be verified by: isMaster=1, whichCore=3, upstream all Null -> exactly one Token slot (data 0, SrcDest 3) INIT_DELAY+1..INIT_DELAY+2 cycles after reset release, tokenLost=0.
REQ-031 SHALL be verified by: barrierDriveRing=1 with type 13, data 0x5, SrcDest 2 -> the same slot on the outputs 1 cycle later; RingIn is ignored.
REQ-032 SHALL be verified by: msgrDriveRing and lockDriveRing both high for 1 cycle -> the messenger slot is forwarded, collision=1 until clearErr, and clearErr+collision in the same cycle keeps collision=1.
REQ-033 SHALL be verified by: master, Token circulating every 50 cycles, TOKEN_TIMEOUT=64 -> no injection; stopping the Token -> a new Token exactly when the first Null arrives after 64 Token-free cycles, tokenLost=1.
REQ-034 SHALL be verified by: INJECT pending while upstream holds non-Null slots for 10 cycles -> all 10 are forwarded intact, and the Token appears on the first Null.
REQ-035 SHALL be verified by: non-master with no Token for 5000 cycles -> no injection, tokenLost=0.
